// File: rtl/alu_pipelined_unit_pkg.sv
// Shared types and build defaults for the pipelined integer ALU unit.
package alu_pipelined_unit_pkg;

    typedef enum logic [1:0] {
        LogicAdd = 2'b00,
        LogicXor = 2'b01,
        LogicOr  = 2'b10,
        LogicAnd = 2'b11
    } alu_logic_op_t;

    localparam int unsigned ALU_STAGES_DEFAULT    = 2;
    localparam int unsigned ENABLE_MINMAX_DEFAULT = 1;

endpackage

// File: rtl/alu_pipelined_unit_shifter.sv
// Barrel shifter: logical/arithmetic right shift, with the result bit-reversed for left shifts
// (decode pre-reverses the source in that case).
module alu_pipelined_unit_shifter #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]         data_i,
    input  logic [$clog2(XLEN)-1:0] amount_i,
    input  logic                    arith_i,
    input  logic                    lshift_i,
    output logic [XLEN-1:0]         result_o
);

    logic            fill;
    logic [XLEN-1:0] shifted;

    always_comb begin
        fill    = arith_i & data_i[XLEN-1];
        shifted = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            shifted[i] = ((i + int'(amount_i)) < int'(XLEN)) ? data_i[i + int'(amount_i)] : fill;
        end
        result_o = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            result_o[i] = lshift_i ? shifted[int'(XLEN) - 1 - i] : shifted[i];
        end
    end

endmodule

// File: rtl/alu_pipelined_unit.sv
// Pipelined integer ALU: single-cycle combinational result, then STAGES register slots with a
// valid/ack writeback handshake that absorbs stalls without loss or reordering.
module alu_pipelined_unit
    import alu_pipelined_unit_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ID_W          = 3,
    parameter int unsigned STAGES        = ALU_STAGES_DEFAULT,
    parameter int unsigned ENABLE_MINMAX = ENABLE_MINMAX_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [ID_W-1:0]         issue_id_i,
    input  logic [XLEN:0]           in1_i,
    input  logic [XLEN:0]           in2_i,
    input  logic [XLEN-1:0]         shifter_in_i,
    input  logic [$clog2(XLEN)-1:0] shift_amount_i,
    input  alu_logic_op_t           logic_op_i,
    input  logic                    subtract_i,
    input  logic                    arith_i,
    input  logic                    lshift_i,
    input  logic                    shifter_path_i,
    input  logic                    slt_path_i,
    input  logic                    minmax_en_i,
    input  logic                    minmax_max_i,
    output logic                    wb_done_o,
    output logic [ID_W-1:0]         wb_id_o,
    output logic [XLEN-1:0]         wb_rd_o,
    input  logic                    wb_ack_i
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] result;
    } alu_stage_t;

    logic            minmax_sel;
    logic            sub;
    logic [XLEN:0]   op_a;
    logic [XLEN:0]   op_b;
    logic [XLEN:0]   adder;
    logic            lt;
    logic [XLEN-1:0] shift_res;
    logic [XLEN-1:0] result;

    alu_pipelined_unit_shifter #(
        .XLEN (XLEN)
    ) u_shifter (
        .data_i   (shifter_in_i),
        .amount_i (shift_amount_i),
        .arith_i  (arith_i),
        .lshift_i (lshift_i),
        .result_o (shift_res)
    );

    always_comb begin
        minmax_sel = (ENABLE_MINMAX != 0) && minmax_en_i;
        // min/max needs the comparison, so it always runs the adder as a subtractor
        sub  = subtract_i | minmax_sel;
        op_b = '0;
        case (logic_op_i)
            LogicXor: op_a = in1_i ^ in2_i;
            LogicOr:  op_a = in1_i | in2_i;
            LogicAnd: op_a = in1_i & in2_i;
            default: begin
                op_a = in1_i;
                op_b = in2_i ^ {(XLEN + 1){sub}};
            end
        endcase
        adder = op_a + op_b + {{XLEN{1'b0}}, sub};
        lt    = adder[XLEN];

        if (minmax_sel) begin
            result = (lt ^ minmax_max_i) ? in1_i[XLEN-1:0] : in2_i[XLEN-1:0];
        end else if (slt_path_i) begin
            result = {{(XLEN - 1){1'b0}}, lt};
        end else if (shifter_path_i) begin
            result = shift_res;
        end else begin
            result = adder[XLEN-1:0];
        end
    end

    alu_stage_t stage_q  [STAGES];
    alu_stage_t stage_in [STAGES];
    logic       load     [STAGES];

    // A slot loads when it is empty or its content moves on this cycle, which collapses bubbles.
    always_comb begin
        stage_in[0].valid  = issue_valid_i;
        stage_in[0].id     = issue_id_i;
        stage_in[0].result = result;
        for (int k = 1; k < int'(STAGES); k++) begin
            stage_in[k] = stage_q[k-1];
        end
        load[STAGES-1] = !stage_q[STAGES-1].valid || wb_ack_i;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            load[k] = !stage_q[k].valid || load[k+1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    stage_q[k].valid <= stage_in[k].valid;
                    if (stage_in[k].valid) begin
                        stage_q[k].id     <= stage_in[k].id;
                        stage_q[k].result <= stage_in[k].result;
                    end
                end
            end
        end
    end

    assign issue_ready_o = load[0];
    assign wb_done_o     = stage_q[STAGES-1].valid;
    assign wb_id_o       = stage_q[STAGES-1].id;
    assign wb_rd_o       = stage_q[STAGES-1].result;

endmodule
